// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - RV32 load/store sequencer driving a byte-wide memory port
`timescale 1ns/1ps

module lsu_byte_sequencer #(
  parameter int MEM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [6:0]                req_opcode,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata
);

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                    state_q;

  // Latched request context
  logic                      is_load_q;
  logic [2:0]                funct3_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [31:0]               wdata_q;
  // idx_q is the byte currently on the bus, last_q is N-1
  logic [1:0]                idx_q;
  logic [1:0]                last_q;
  // Load assembly register; lanes never read stay zero
  logic [31:0]               asm_q;
  logic [31:0]               asm_d;

  // Registered outputs
  logic                      resp_valid_q;
  logic [31:0]               resp_rdata_q;
  logic                      resp_err_q;
  logic                      mem_en_q;
  logic                      mem_we_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]                mem_wdata_q;

  // Request decode
  logic                      req_is_store;
  logic                      req_is_load;
  logic                      req_legal;
  logic [1:0]                req_last;

  // Next-byte helpers for ACCESS
  logic [1:0]                idx_n;
  logic [MEM_ADDR_WIDTH-1:0] next_addr;
  logic [7:0]                next_wbyte;

  // Load capture and extension
  logic                      cap_en;
  logic [1:0]                cap_lane;
  logic [31:0]               load_result;

  // Upper address bits fall outside the memory space by design
  logic                      unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_WIDTH];

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  assign req_is_store = (req_opcode == OP_STORE);
  assign req_is_load  = (req_opcode == OP_LOAD);

  // Classify funct3 legality for the incoming opcode and derive N-1
  always_comb begin
    req_legal = 1'b0;
    if (req_is_store) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        default:                req_legal = 1'b0;
      endcase
    end else if (req_is_load) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        default:                                req_legal = 1'b0;
      endcase
    end
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  assign idx_n      = idx_q + 2'd1;
  assign next_addr  = base_q + MEM_ADDR_WIDTH'(idx_n);
  assign next_wbyte = wdata_q[{idx_n, 3'b000} +: 8];

  // Merge the returning read byte into its lane; data lags the read by one cycle
  always_comb begin
    cap_en   = 1'b0;
    cap_lane = 2'd0;
    if (state_q == S_ACCESS && is_load_q && idx_q != 2'd0) begin
      cap_en   = 1'b1;
      cap_lane = idx_q - 2'd1;
    end else if (state_q == S_DRAIN) begin
      cap_en   = 1'b1;
      cap_lane = last_q;
    end
    asm_d = asm_q;
    if (cap_en) begin
      asm_d[{cap_lane, 3'b000} +: 8] = mem_rdata;
    end
  end

  // Sign/zero extension of the fully assembled load value
  always_comb begin
    case (funct3_q)
      3'b000:  load_result = {{24{asm_d[7]}}, asm_d[7:0]};
      3'b001:  load_result = {{16{asm_d[15]}}, asm_d[15:0]};
      default: load_result = asm_d;
    endcase
  end

  // Sequencer FSM with registered memory-port and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      base_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      asm_q        <= asm_d;

      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            is_load_q <= req_is_load;
            funct3_q  <= req_funct3;
            base_q    <= req_addr[MEM_ADDR_WIDTH-1:0];
            wdata_q   <= req_wdata;
            idx_q     <= 2'd0;
            last_q    <= req_last;
            asm_q     <= '0;
            if ((req_is_store || req_is_load) && req_legal) begin
              // Byte 0 goes out on the cycle after acceptance
              state_q     <= S_ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req_is_store;
              mem_addr_q  <= req_addr[MEM_ADDR_WIDTH-1:0];
              mem_wdata_q <= req_is_store ? req_wdata[7:0] : 8'h00;
            end else if (req_is_store || req_is_load) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= req_wdata;
            end
          end
        end

        S_ACCESS: begin
          if (idx_q == last_q) begin
            if (is_load_q) begin
              // Final read byte still in flight
              state_q <= S_DRAIN;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end
          end else begin
            idx_q       <= idx_n;
            mem_en_q    <= 1'b1;
            mem_we_q    <= !is_load_q;
            mem_addr_q  <= next_addr;
            mem_wdata_q <= is_load_q ? 8'h00 : next_wbyte;
          end
        end

        S_DRAIN: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_result;
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
